conv3x3_filter: RTL and testbench
=================================

// Module: conv3x3_filter
//
// PURPOSE
// Parametrised 3x3 neighbourhood filter for the greyscale pixel stream, the
// successor to the fixed box-blur stage. Buffers the two previous lines plus a
// 3x3 window and supports box blur, Gaussian blur, sharpen and passthrough.
// Uses full valid/ready backpressure and frame framing, so it slots between
// any two stream stages of the pixel-wise filter chain.
//
// PARAMETERS
// DATA_WIDTH  8    pixel width, unsigned
// IMG_WIDTH   640  pixels per line (>=3)
// IMG_HEIGHT  480  lines per frame (>=3)
//
// PORTS
// clk             in   1           system clock, rising edge
// reset           in   1           asynchronous, active-high
// mode            in   2           00 pass, 01 box, 10 gaussian, 11 sharpen
// pixel_in        in   DATA_WIDTH  input pixel, raster order
// pixel_in_sof    in   1           high with first pixel of a frame
// pixel_in_valid  in   1           input beat valid
// pixel_in_ready  out  1           block can accept a beat
// pixel_out       out  DATA_WIDTH  filtered pixel
// pixel_out_eof   out  1           high with last output pixel of a frame
// pixel_out_valid out  1           output beat valid
// pixel_out_ready in   1           downstream accepts beat
//
// BEHAVIOUR
// - Reset: pixel_out=0, pixel_out_valid=0, pixel_out_eof=0, row/col counters=0,
//   pipeline valid bits=0, latched mode=00. Line-buffer contents undefined.
// - Input accepted on pixel_in_valid && pixel_in_ready. Output transferred on
//   pixel_out_valid && pixel_out_ready.
// - Pipeline enable en = !(pixel_out_valid && !pixel_out_ready);
//   pixel_in_ready = en (combinational). No beats lost or duplicated under stall.
// - Counters col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1 advance per accepted beat;
//   col wraps to 0 and increments row; row wraps to 0 after last pixel of frame.
// - Accepted beat with pixel_in_sof=1 forces row=col=0 for that pixel (resync),
//   discards window/line history validity, and latches mode. mode is ignored
//   at all other times; change takes effect only at next SOF.
// - Output only for interior centres: accepted pixel at (r,c) with r>=2, c>=2
//   produces the output for centre (r-1,c-1). Exactly (W-2)*(H-2) outputs per
//   frame; border pixels produce no output.
// - Latency: 2 enabled cycles. Stage 1 registers window sums; stage 2 registers
//   pixel_out. With out_ready held high, output appears 2 clocks after accept.
// - Window P[i][j], i=row -1..+1, j=col -1..+1, centre C=P[0][0]:
//   00: C.
//   01: floor(sum of 9 / 9); exact integer divide, sum width DATA_WIDTH+4.
//   10: (1 2 1 / 2 4 2 / 1 2 1) sum, then (sum+8)>>4 (round half up).
//   11: 5*C - N - S - E - W, signed, clamped to [0, 2^DATA_WIDTH-1].
// - pixel_out_eof=1 with output for centre (H-2,W-2); else 0.
// - SOF mid-frame: in-flight outputs of old frame still drain in order; new
//   frame restarts counters; no eof for the aborted frame.
// - Reset mid-frame: all state cleared immediately; next frame needs SOF or
//   starts from (0,0).
//
// TESTING
// - W=H=4, mode=01, all pixels 90 -> 4 outputs of 90, eof on 4th only.
// - W=H=3, mode=10, centre 255 rest 0 -> one output (1020+8)>>4=64, eof=1.
// - W=H=3, mode=11, centre 200 N/S/E/W 255 -> 0 (clamp); centre 100 rest 10
//   -> 460 clamps 255.
// - W=H=5 ramp px=row*5+col, mode=00, out_ready toggled 1/0 randomly -> 9
//   outputs 6,7,8,11,12,13,16,17,18 in order, none dropped/duplicated.
// - Change mode mid-frame 01->11 -> whole frame stays box; next SOF uses sharpen.
// - Assert reset after 7 beats of 4x4 frame -> out_valid=0 next edge, then
//   fresh SOF frame yields correct 4 outputs.

Source files
------------

// File: rtl/conv3x3_filter.sv
// ---------------------------------------------------------------------------
// conv3x3_filter
//
// Purpose:
//   3x3 neighbourhood filter for a raster-order greyscale pixel stream.
//   Two line buffers plus a 3x3 window feed a two-stage pipeline that
//   implements passthrough, box blur, Gaussian blur and sharpen.
//   Full valid/ready handshaking on both sides. Frames are delimited by
//   pixel_in_sof on input and pixel_out_eof on output.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high
//   mode            filter select (00 pass, 01 box, 10 gaussian, 11 sharpen),
//                   sampled only on the accepted SOF beat
//   pixel_in        input pixel, raster order
//   pixel_in_sof    marks the first pixel of a frame
//   pixel_in_valid  input beat valid
//   pixel_in_ready  block can accept a beat (combinational from pipeline state)
//   pixel_out       filtered pixel
//   pixel_out_eof   marks the last output pixel of a frame
//   pixel_out_valid output beat valid
//   pixel_out_ready downstream accepts the beat
// ---------------------------------------------------------------------------
module conv3x3_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_sof,
    input  logic                  pixel_in_valid,
    output logic                  pixel_in_ready,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_out_eof,
    output logic                  pixel_out_valid,
    input  logic                  pixel_out_ready
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int SW = DATA_WIDTH + 4;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_BOX   = 2'b01;
    localparam logic [1:0] MODE_GAUSS = 2'b10;
    localparam logic [1:0] MODE_SHARP = 2'b11;

    localparam logic signed [SW:0] PIX_MAX = {5'b00000, {DATA_WIDTH{1'b1}}};

    logic                  en;
    logic                  accept;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [RW-1:0]         cur_row;
    logic [CW-1:0]         cur_col;
    logic                  interior;
    logic                  last_centre;
    logic [1:0]            mode_q;

    logic [DATA_WIDTH-1:0] line0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win_l [3];
    logic [DATA_WIDTH-1:0] win_m [3];
    logic [DATA_WIDTH-1:0] col_top;
    logic [DATA_WIDTH-1:0] col_mid;

    logic [SW-1:0]         box_sum;
    logic [SW-1:0]         gauss_sum;
    logic [SW-1:0]         sharp_pos;
    logic [SW-1:0]         sharp_neg;
    logic signed [SW:0]    s1_next;

    logic                  s1_valid;
    logic                  s1_eof;
    logic [1:0]            s1_mode;
    logic signed [SW:0]    s1_val;
    logic [DATA_WIDTH-1:0] out_next;

    // The whole pipeline freezes only when an output is held by downstream.
    assign en             = !(pixel_out_valid && !pixel_out_ready);
    assign pixel_in_ready = en;
    assign accept         = pixel_in_valid && en;

    // A SOF beat is treated as pixel (0,0) regardless of where the counters
    // were, so a truncated frame resynchronises cleanly.
    always_comb begin
        cur_row     = pixel_in_sof ? '0 : row;
        cur_col     = pixel_in_sof ? '0 : col;
        interior    = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_centre = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
        col_top     = line0[cur_col];
        col_mid     = line1[cur_col];
    end

    // Window taps: win_l holds column c-2, win_m column c-1, and the incoming
    // column c comes straight from the line buffers plus the new pixel, so the
    // centre of the completed window is win_m[1] at (row-1, col-1).
    always_comb begin
        box_sum   = SW'(win_l[0]) + SW'(win_m[0]) + SW'(col_top)
                  + SW'(win_l[1]) + SW'(win_m[1]) + SW'(col_mid)
                  + SW'(win_l[2]) + SW'(win_m[2]) + SW'(pixel_in);
        gauss_sum = SW'(win_l[0]) + (SW'(win_m[0]) << 1) + SW'(col_top)
                  + (SW'(win_l[1]) << 1) + (SW'(win_m[1]) << 2) + (SW'(col_mid) << 1)
                  + SW'(win_l[2]) + (SW'(win_m[2]) << 1) + SW'(pixel_in);
        sharp_pos = (SW'(win_m[1]) << 2) + SW'(win_m[1]);
        sharp_neg = SW'(win_m[0]) + SW'(win_m[2]) + SW'(win_l[1]) + SW'(col_mid);
        s1_next   = '0;
        case (mode_q)
            MODE_PASS:  s1_next = $signed({1'b0, SW'(win_m[1])});
            MODE_BOX:   s1_next = $signed({1'b0, box_sum});
            MODE_GAUSS: s1_next = $signed({1'b0, gauss_sum});
            MODE_SHARP: s1_next = $signed({1'b0, sharp_pos}) - $signed({1'b0, sharp_neg});
            default:    s1_next = '0;
        endcase
    end

    // Stage 2 normalisation: divide, round or clamp the registered sum
    // according to the mode that was active when the window was captured.
    always_comb begin
        out_next = '0;
        case (s1_mode)
            MODE_PASS:  out_next = s1_val[DATA_WIDTH-1:0];
            MODE_BOX:   out_next = DATA_WIDTH'(s1_val[SW-1:0] / SW'(9));
            MODE_GAUSS: out_next = DATA_WIDTH'((s1_val[SW-1:0] + SW'(8)) >> 4);
            MODE_SHARP: begin
                if (s1_val < 0)
                    out_next = '0;
                else if (s1_val > PIX_MAX)
                    out_next = '1;
                else
                    out_next = s1_val[DATA_WIDTH-1:0];
            end
            default:    out_next = '0;
        endcase
    end

    // Line buffers and window shift. No reset: the row/col counters alone
    // decide when their contents belong to the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            line0[cur_col] <= col_mid;
            line1[cur_col] <= pixel_in;
            win_l          <= win_m;
            win_m[0]       <= col_top;
            win_m[1]       <= col_mid;
            win_m[2]       <= pixel_in;
        end
    end

    // Position counters, mode latch and the two pipeline stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row             <= '0;
            col             <= '0;
            mode_q          <= MODE_PASS;
            s1_valid        <= 1'b0;
            s1_eof          <= 1'b0;
            s1_mode         <= MODE_PASS;
            s1_val          <= '0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            pixel_out_eof   <= 1'b0;
        end else begin
            if (accept) begin
                if (cur_col == CW'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
                if (pixel_in_sof)
                    mode_q <= mode;
            end
            if (en) begin
                s1_valid <= accept && interior;
                s1_eof   <= accept && last_centre;
                if (accept) begin
                    s1_mode <= mode_q;
                    s1_val  <= s1_next;
                end
                pixel_out_valid <= s1_valid;
                pixel_out_eof   <= s1_valid && s1_eof;
                if (s1_valid)
                    pixel_out <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_filter.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_filter
//
// Purpose:
//   Self-checking bench for conv3x3_filter. Three instances (3x3, 4x4 and
//   5x5 frames) share the input bus; sel chooses which one receives beats
//   and whose outputs are collected and compared.
// ---------------------------------------------------------------------------
module tb_conv3x3_filter;

    typedef struct {
        logic [1:0]      mode;
        logic [8:0][7:0] px;
        logic [7:0]      exp_px;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] pixel_in = '0;
    logic       pixel_in_sof = 1'b0;
    logic       pixel_in_valid = 1'b0;
    logic       pixel_out_ready = 1'b1;
    logic [2:0] sel = 3'd3;

    logic       rand_ready = 1'b0;
    logic       hold_low = 1'b0;

    logic       v3, v4, v5;
    logic       r3, r4, r5;
    logic [7:0] o3, o4, o5;
    logic       e3, e4, e5;
    logic       ov3, ov4, ov5;

    logic       cur_ready;
    logic [7:0] cur_out;
    logic       cur_eof;
    logic       cur_valid;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_px[$];
    logic [7:0] got_px[$];
    logic       got_eof[$];
    vec_t       vecs[15];

    always #5 clk = ~clk;

    assign v3 = pixel_in_valid && (sel == 3'd3);
    assign v4 = pixel_in_valid && (sel == 3'd4);
    assign v5 = pixel_in_valid && (sel == 3'd5);

    conv3x3_filter #(.DATA_WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk(clk), .reset(reset), .mode(mode), .pixel_in(pixel_in),
        .pixel_in_sof(pixel_in_sof), .pixel_in_valid(v3), .pixel_in_ready(r3),
        .pixel_out(o3), .pixel_out_eof(e3), .pixel_out_valid(ov3),
        .pixel_out_ready(pixel_out_ready)
    );

    conv3x3_filter #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .pixel_in(pixel_in),
        .pixel_in_sof(pixel_in_sof), .pixel_in_valid(v4), .pixel_in_ready(r4),
        .pixel_out(o4), .pixel_out_eof(e4), .pixel_out_valid(ov4),
        .pixel_out_ready(pixel_out_ready)
    );

    conv3x3_filter #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk(clk), .reset(reset), .mode(mode), .pixel_in(pixel_in),
        .pixel_in_sof(pixel_in_sof), .pixel_in_valid(v5), .pixel_in_ready(r5),
        .pixel_out(o5), .pixel_out_eof(e5), .pixel_out_valid(ov5),
        .pixel_out_ready(pixel_out_ready)
    );

    // Route the selected instance onto common observation signals.
    always_comb begin
        cur_ready = r3;
        cur_out   = o3;
        cur_eof   = e3;
        cur_valid = ov3;
        case (sel)
            3'd4: begin cur_ready = r4; cur_out = o4; cur_eof = e4; cur_valid = ov4; end
            3'd5: begin cur_ready = r5; cur_out = o5; cur_eof = e5; cur_valid = ov5; end
            default: ;
        endcase
    end

    // Downstream model: ready held high, forced low, or randomly toggled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_low)
                pixel_out_ready = 1'b0;
            else if (rand_ready)
                pixel_out_ready = 1'($urandom_range(0, 1));
            else
                pixel_out_ready = 1'b1;
        end
    end

    // Every completed output transfer of the selected instance is recorded.
    always @(negedge clk) begin
        if (!reset && cur_valid && pixel_out_ready) begin
            got_px.push_back(cur_out);
            got_eof.push_back(cur_eof);
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0][7:0] sym(input logic [7:0] ctr, input logic [7:0] nsew,
                                            input logic [7:0] corner);
        logic [8:0][7:0] r;
        for (int k = 0; k < 9; k++)
            r[k] = corner;
        r[1] = nsew;
        r[3] = nsew;
        r[5] = nsew;
        r[7] = nsew;
        r[4] = ctr;
        return r;
    endfunction

    function automatic logic [8:0][7:0] ramp(input int base, input int step);
        logic [8:0][7:0] r;
        for (int k = 0; k < 9; k++)
            r[k] = 8'(base + k * step);
        return r;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, actual, expected);
        end
    endtask

    // Present one beat and hold it until the selected instance accepts it.
    task automatic apply_stimulus(input logic [7:0] px, input logic sof);
        int n;
        pixel_in       = px;
        pixel_in_sof   = sof;
        pixel_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cur_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            check_output("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
        pixel_in_sof   = 1'b0;
    endtask

    // kind: 0 spike (100 at (1,1), 10 elsewhere), 1 ramp r*w+c, 2 flat 90, 3 flat 200
    task automatic send_frame(input int w, input int h, input int kind, input int beats,
                              input bit gaps, input logic [1:0] m_first,
                              input logic [1:0] m_rest);
        int r;
        int c;
        logic [7:0] px;
        mode = m_first;
        for (int idx = 0; idx < beats && idx < w * h; idx++) begin
            r = idx / w;
            c = idx % w;
            case (kind)
                0:       px = (r == 1 && c == 1) ? 8'd100 : 8'd10;
                1:       px = 8'(r * w + c);
                2:       px = 8'd90;
                default: px = 8'd200;
            endcase
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            apply_stimulus(px, idx == 0);
            if (idx == 0)
                mode = m_rest;
        end
    endtask

    task automatic clear_frame();
        got_px.delete();
        got_eof.delete();
        exp_px.delete();
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic compare_frame(input string name);
        check_output({name, "_count"}, got_px.size(), exp_px.size());
        for (int i = 0; i < exp_px.size(); i++) begin
            if (i < got_px.size()) begin
                check_output($sformatf("%s_px%0d", name, i), got_px[i], exp_px[i]);
                check_output($sformatf("%s_eof%0d", name, i), got_eof[i],
                             (i == exp_px.size() - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic expect_four(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        exp_px.push_back(a);
        exp_px.push_back(b);
        exp_px.push_back(c);
        exp_px.push_back(d);
    endtask

    initial begin
        // 3x3 single-output vectors: {mode, pixels row-major, expected centre}
        vecs[0]  = '{2'b00, sym(8'd123, 8'd7, 8'd9),    8'd123};
        vecs[1]  = '{2'b01, sym(8'd17, 8'd0, 8'd0),     8'd1};
        vecs[2]  = '{2'b01, sym(8'd255, 8'd255, 8'd255), 8'd255};
        vecs[3]  = '{2'b01, ramp(10, 10),               8'd50};
        vecs[4]  = '{2'b10, sym(8'd255, 8'd0, 8'd0),    8'd64};
        vecs[5]  = '{2'b10, sym(8'd2, 8'd0, 8'd0),      8'd1};
        vecs[6]  = '{2'b10, sym(8'd0, 8'd0, 8'd1),      8'd0};
        vecs[7]  = '{2'b10, sym(8'd1, 8'd0, 8'd1),      8'd1};
        vecs[8]  = '{2'b10, sym(8'd255, 8'd255, 8'd255), 8'd255};
        vecs[9]  = '{2'b11, sym(8'd200, 8'd255, 8'd0),  8'd0};
        vecs[10] = '{2'b11, sym(8'd100, 8'd10, 8'd10),  8'd255};
        vecs[11] = '{2'b11, sym(8'd51, 8'd0, 8'd99),    8'd255};
        vecs[12] = '{2'b11, sym(8'd60, 8'd76, 8'd0),    8'd0};
        vecs[13] = '{2'b11, sym(8'd50, 8'd40, 8'd40),   8'd90};
        vecs[14] = '{2'b10, ramp(10, 10),               8'd50};

        // Reset state
        sel = 3'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_valid", cur_valid, 0);
        check_output("rst_px", cur_out, 0);
        check_output("rst_eof", cur_eof, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_in_ready", cur_ready, 1);
        @(posedge clk);
        #1;

        // Table: one 3x3 frame per vector; mode is scrambled after SOF to
        // confirm that only the SOF-time value matters.
        for (int i = 0; i < 15; i++) begin
            clear_frame();
            exp_px.push_back(vecs[i].exp_px);
            mode = vecs[i].mode;
            apply_stimulus(vecs[i].px[0], 1'b1);
            mode = ~vecs[i].mode;
            for (int k = 1; k < 9; k++)
                apply_stimulus(vecs[i].px[k], 1'b0);
            @(negedge clk);
            check_output($sformatf("vec%0d_lat1", i), cur_valid, 0);
            @(negedge clk);
            check_output($sformatf("vec%0d_lat2", i), cur_valid, 1);
            drain(10);
            compare_frame($sformatf("vec%0d", i));
        end

        // 4x4 flat box blur
        sel = 3'd4;
        clear_frame();
        expect_four(8'd90, 8'd90, 8'd90, 8'd90);
        send_frame(4, 4, 2, 16, 1'b0, 2'b01, 2'b01);
        drain(10);
        compare_frame("box4");

        // Mode changed mid-frame stays box; next SOF uses sharpen
        clear_frame();
        expect_four(8'd20, 8'd20, 8'd20, 8'd20);
        send_frame(4, 4, 0, 16, 1'b0, 2'b01, 2'b11);
        drain(10);
        compare_frame("modechg_box");
        clear_frame();
        expect_four(8'd255, 8'd0, 8'd0, 8'd10);
        send_frame(4, 4, 0, 16, 1'b0, 2'b11, 2'b11);
        drain(10);
        compare_frame("modechg_sharp");

        // SOF arriving mid-frame resynchronises; aborted frame yields nothing
        clear_frame();
        expect_four(8'd20, 8'd20, 8'd20, 8'd20);
        send_frame(4, 4, 3, 6, 1'b0, 2'b01, 2'b01);
        send_frame(4, 4, 0, 16, 1'b0, 2'b01, 2'b01);
        drain(10);
        compare_frame("resync");

        // Reset after 7 beats, then a fresh frame
        clear_frame();
        send_frame(4, 4, 0, 7, 1'b0, 2'b01, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        check_output("rst7_valid", cur_valid, 0);
        check_output("rst7_in_ready", cur_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_four(8'd20, 8'd20, 8'd20, 8'd20);
        send_frame(4, 4, 0, 16, 1'b0, 2'b01, 2'b01);
        drain(10);
        compare_frame("after_rst7");

        // Reset while an output is stalled by downstream
        clear_frame();
        hold_low = 1'b1;
        drain(2);
        send_frame(4, 4, 0, 11, 1'b0, 2'b01, 2'b01);
        drain(3);
        @(negedge clk);
        check_output("stall_valid", cur_valid, 1);
        check_output("stall_px", cur_out, 20);
        check_output("stall_in_ready", cur_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_output("stall_rst_valid", cur_valid, 0);
        check_output("stall_rst_px", cur_out, 0);
        hold_low = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drain(2);
        clear_frame();
        expect_four(8'd20, 8'd20, 8'd20, 8'd20);
        send_frame(4, 4, 0, 16, 1'b0, 2'b01, 2'b01);
        drain(10);
        compare_frame("after_stall_rst");

        // 5x5 ramp passthrough under random backpressure and input gaps
        sel = 3'd5;
        clear_frame();
        exp_px = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
        rand_ready = 1'b1;
        send_frame(5, 5, 1, 25, 1'b1, 2'b00, 2'b01);
        drain(20);
        rand_ready = 1'b0;
        drain(25);
        compare_frame("ramp5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
